// File: rtl/can_tx_scheduler_pkg.sv
// Shared constants and FSM encoding for the CAN transmit scheduler and its helpers.
package can_tx_scheduler_pkg;

  localparam int   CAN_ID_W      = 11;
  localparam logic BUS_DOMINANT  = 1'b1;
  localparam int   CAN_IDLE_BITS = 11;

  typedef enum logic [1:0] {
    S_WAIT,
    S_GRANT,
    S_START,
    S_ACTIVE
  } state_e;

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Mailbox/node-facing bundle of the transmit scheduler; master = scheduler side.
interface can_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 11
);
  logic                 bit_tick;
  logic                 bus_dom;
  logic [NREQ-1:0]      req;
  logic [NREQ*ID_W-1:0] req_id;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      fail;
  logic                 tx_start;
  logic [ID_W-1:0]      tx_id;
  logic                 tx_done;
  logic                 tx_lost;
  logic                 tx_err;
  logic                 bus_idle;

  modport master (
    input  bit_tick, bus_dom, req, req_id, tx_done, tx_lost, tx_err,
    output gnt, done, fail, tx_start, tx_id, bus_idle
  );

  modport slave (
    output bit_tick, bus_dom, req, req_id, tx_done, tx_lost, tx_err,
    input  gnt, done, fail, tx_start, tx_id, bus_idle
  );
endinterface

// File: rtl/can_prio_select.sv
// Combinational CAN priority pick: lowest ID among asserted requests, lowest index on ties.
module can_prio_select #(
  parameter int NREQ = 4,
  parameter int ID_W = 11
) (
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*ID_W-1:0] id_i,
  output logic [NREQ-1:0]      win_oh_o,
  output logic [ID_W-1:0]      win_id_o,
  output logic                 vld_o
);

  always_comb begin
    win_oh_o = '0;
    win_id_o = '0;
    vld_o    = 1'b0;
    // Strict less-than keeps the earlier (lower) index on equal IDs.
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i] && (!vld_o || (id_i[i*ID_W +: ID_W] < win_id_o))) begin
        win_oh_o    = '0;
        win_oh_o[i] = 1'b1;
        win_id_o    = id_i[i*ID_W +: ID_W];
        vld_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Arbitrates NREQ mailboxes onto one CAN transmitter: waits for bus idle, grants lowest ID,
// sequences tx_start and resolves done / lost arbitration / error with a per-mailbox retry limit.
module can_tx_scheduler
  import can_tx_scheduler_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ID_W      = CAN_ID_W,
  parameter int IDLE_BITS = CAN_IDLE_BITS,
  parameter int MAX_RETRY = 8,
  parameter int RETRY_W   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  can_tx_scheduler_if.master  sif
);

  localparam int CNT_W = $clog2(IDLE_BITS + 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               idle_cnt_q, idle_cnt_d;
  logic [NREQ-1:0]                win_q, win_d;
  logic [NREQ-1:0]                gnt_q, gnt_d;
  logic [NREQ-1:0]                done_q, done_d;
  logic [NREQ-1:0]                fail_q, fail_d;
  logic                           tx_start_q, tx_start_d;
  logic [ID_W-1:0]                tx_id_q, tx_id_d;
  logic [NREQ-1:0][RETRY_W-1:0]   retry_q, retry_d;

  logic [NREQ-1:0] sel_oh;
  logic [ID_W-1:0] sel_id;
  logic            sel_vld;
  logic            bus_idle;
  logic            fin_done, fin_err, fin_any;

  can_prio_select #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_sel (
    .req_i    (sif.req),
    .id_i     (sif.req_id),
    .win_oh_o (sel_oh),
    .win_id_o (sel_id),
    .vld_o    (sel_vld)
  );

  assign bus_idle = (idle_cnt_q == CNT_W'(IDLE_BITS));

  // Node events only matter in ACTIVE; done outranks err, err outranks lost.
  assign fin_done = (state_q == S_ACTIVE) && sif.tx_done;
  assign fin_err  = (state_q == S_ACTIVE) && !sif.tx_done && sif.tx_err;
  assign fin_any  = (state_q == S_ACTIVE) && (sif.tx_done || sif.tx_err || sif.tx_lost);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT;
      idle_cnt_q <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      fail_q     <= '0;
      tx_start_q <= 1'b0;
      tx_id_q    <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      tx_start_q <= tx_start_d;
      tx_id_q    <= tx_id_d;
      retry_q    <= retry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    fail_d     = '0;
    tx_start_d = 1'b0;
    tx_id_d    = tx_id_q;
    retry_d    = retry_q;

    if (sif.bit_tick) begin
      if (sif.bus_dom == BUS_DOMINANT) idle_cnt_d = '0;
      else if (!bus_idle)              idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_WAIT: begin
        if (bus_idle && sel_vld) begin
          win_d   = sel_oh;
          gnt_d   = sel_oh;
          tx_id_d = sel_id;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        tx_start_d = 1'b1;
        state_d    = S_START;
      end
      S_START: state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (fin_any) begin
          gnt_d      = '0;
          idle_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase

    for (int i = 0; i < NREQ; i++) begin
      if (win_q[i]) begin
        if (fin_done) begin
          done_d[i]  = 1'b1;
          retry_d[i] = '0;
        end else if (fin_err) begin
          if (retry_q[i] + RETRY_W'(1) == RETRY_W'(MAX_RETRY)) begin
            fail_d[i]  = 1'b1;
            retry_d[i] = '0;
          end else begin
            retry_d[i] = retry_q[i] + RETRY_W'(1);
          end
        end
      end
    end
  end

  assign sif.gnt      = gnt_q;
  assign sif.done     = done_q;
  assign sif.fail     = fail_q;
  assign sif.tx_start = tx_start_q;
  assign sif.tx_id    = tx_id_q;
  assign sif.bus_idle = bus_idle;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed frame table, mid-frame reset, and randomized frames
// scored against an idle-run / lowest-key / retry-count model.
module tb_can_tx_scheduler;
  localparam int NREQ = 4, ID_W = 11, IDLE = 11, MAXR = 3, RW = 4;
  localparam logic [2:0] EV_D = 3'b100, EV_E = 3'b010, EV_L = 3'b001;

  typedef logic [NREQ-1:0][ID_W-1:0] ids_t;
  typedef struct {
    logic [NREQ-1:0] req;
    ids_t            ids;
    int              dom_tick;
    logic [2:0]      ev;
    logic [NREQ-1:0] exp_gnt;
    logic [ID_W-1:0] exp_id;
    logic [NREQ-1:0] exp_done;
    logic [NREQ-1:0] exp_fail;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  can_tx_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) sif ();

  can_tx_scheduler #(
    .NREQ(NREQ), .ID_W(ID_W), .IDLE_BITS(IDLE), .MAX_RETRY(MAXR), .RETRY_W(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int   checks = 0;
  int   errors = 0;
  int   run    = 0;
  int   rc[NREQ];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ids_t mk(input int a, input int b, input int c, input int d);
    ids_t r;
    r[0] = ID_W'(a); r[1] = ID_W'(b); r[2] = ID_W'(c); r[3] = ID_W'(d);
    return r;
  endfunction

  task automatic add(input logic [NREQ-1:0] req, input ids_t ids, input int dt, input logic [2:0] ev,
                     input logic [NREQ-1:0] g, input int id, input logic [NREQ-1:0] d,
                     input logic [NREQ-1:0] f);
    vec_t v;
    v.req = req; v.ids = ids; v.dom_tick = dt; v.ev = ev;
    v.exp_gnt = g; v.exp_id = ID_W'(id); v.exp_done = d; v.exp_fail = f;
    tbl.push_back(v);
  endtask

  // One arbitration round: idle wait, grant, start, then a single node event.
  task automatic do_frame(input logic [NREQ-1:0] req, input ids_t ids, input int dom_tick,
                          input logic [2:0] ev, input bit rnd,
                          output logic [NREQ-1:0] o_gnt, output logic [ID_W-1:0] o_id,
                          output logic [NREQ-1:0] o_done, output logic [NREQ-1:0] o_fail);
    int e, idle_e, ntick, d;
    bit tk, dm, got;
    sif.req = req; sif.req_id = ids;
    o_gnt = '0; o_id = '0; o_done = '0; o_fail = '0;
    idle_e = (run == IDLE) ? 0 : -1;
    e = 0; ntick = 0; got = 0;
    while (!got && e < 400) begin
      tk = rnd ? ($urandom_range(0, 2) == 0) : (e % 4 == 3);
      dm = 1'b0;
      if (tk) begin
        ntick++;
        dm = rnd ? ($urandom_range(0, 11) == 0) : (ntick == dom_tick);
      end else if (rnd) dm = 1'($urandom_range(0, 1));
      sif.bit_tick = tk; sif.bus_dom = dm;
      sif.tx_done = rnd && ($urandom_range(0, 9) == 0);
      sif.tx_err  = rnd && ($urandom_range(0, 9) == 0);
      sif.tx_lost = rnd && ($urandom_range(0, 9) == 0);
      step();
      e++;
      if (tk) run = dm ? 0 : ((run < IDLE) ? run + 1 : IDLE);
      if (idle_e < 0 && run == IDLE) idle_e = e;
      if (idle_e >= 0 && e == idle_e + 1) o_gnt = sif.gnt;
      if (idle_e >= 0 && e == idle_e + 2) begin
        chk("tx_start_latency", sif.tx_start, 1);
        o_id = sif.tx_id;
        got  = 1;
      end else chk("no_early_start", sif.tx_start, 0);
    end
    sif.tx_done = 0; sif.tx_err = 0; sif.tx_lost = 0;
    if (!got) timeout("grant_wait");
    d = rnd ? $urandom_range(1, 4) : 2;
    repeat (d) begin
      sif.bit_tick = rnd && ($urandom_range(0, 2) == 0);
      sif.bus_dom  = rnd && ($urandom_range(0, 1) == 0);
      step();
      chk("gnt_hold", sif.gnt, o_gnt);
      chk("start_one_shot", sif.tx_start, 0);
    end
    chk("tx_id_stable", sif.tx_id, o_id);
    sif.bit_tick = 0;
    {sif.tx_done, sif.tx_err, sif.tx_lost} = ev;
    step();
    run = 0;
    o_done = sif.done; o_fail = sif.fail;
    chk("gnt_release", sif.gnt, 0);
    chk("bus_idle_clear", sif.bus_idle, 0);
    sif.tx_done = 0; sif.tx_err = 0; sif.tx_lost = 0;
    step();
    chk("done_fail_one_shot", {sif.done, sif.fail}, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] g, dn, fl, m, oh;
    logic [ID_W-1:0] id;
    ids_t ids;
    int n, best, w, key;
    bit got;
    logic [2:0] ev;

    rst_n = 1'b0;
    sif.bit_tick = 0; sif.bus_dom = 0; sif.req = '0; sif.req_id = '0;
    sif.tx_done = 0; sif.tx_err = 0; sif.tx_lost = 0;
    foreach (rc[i]) rc[i] = 0;
    #23 rst_n = 1'b1;
    step();
    chk("rst_gnt", sif.gnt, 0);
    chk("rst_done_fail", {sif.done, sif.fail}, 0);
    chk("rst_tx_start", sif.tx_start, 0);
    chk("rst_tx_id", sif.tx_id, 0);
    chk("rst_bus_idle", sif.bus_idle, 0);

    add(4'b0001, mk('h123, 0, 0, 0),         0, EV_D, 4'b0001, 'h123, 4'b0001, 4'b0000);
    add(4'b0110, mk(0, 'h050, 'h700, 0),     0, EV_D, 4'b0010, 'h050, 4'b0010, 4'b0000);
    add(4'b0100, mk(0, 'h050, 'h700, 0),     0, EV_D, 4'b0100, 'h700, 4'b0100, 4'b0000);
    add(4'b1001, mk('h100, 0, 0, 'h100),     7, EV_D, 4'b0001, 'h100, 4'b0001, 4'b0000);
    add(4'b1000, mk('h100, 0, 0, 'h100),     0, EV_L, 4'b1000, 'h100, 4'b0000, 4'b0000);
    add(4'b1000, mk('h100, 0, 0, 'h100),     0, EV_D, 4'b1000, 'h100, 4'b1000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0100);
    for (int k = 0; k < 5; k++)
      add(4'b0100, mk(0, 0, 'h200, 0),       0, EV_L, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_D, 4'b0100, 'h200, 4'b0100, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_D | EV_E, 4'b0100, 'h200, 4'b0100, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E, 4'b0100, 'h200, 4'b0000, 4'b0100);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_E | EV_L, 4'b0100, 'h200, 4'b0000, 4'b0000);
    add(4'b0100, mk(0, 0, 'h200, 0),         0, EV_D | EV_E | EV_L, 4'b0100, 'h200, 4'b0100, 4'b0000);
    add(4'b1111, mk('h7FF, 0, 'h7FF, 0),     0, EV_D, 4'b0010, 'h000, 4'b0010, 4'b0000);
    add(4'b1101, mk('h7FF, 0, 'h7FF, 1),     0, EV_D, 4'b1000, 'h001, 4'b1000, 4'b0000);

    foreach (tbl[i]) begin
      do_frame(tbl[i].req, tbl[i].ids, tbl[i].dom_tick, tbl[i].ev, 1'b0, g, id, dn, fl);
      chk($sformatf("v%0d_gnt", i),  g,  tbl[i].exp_gnt);
      chk($sformatf("v%0d_id", i),   id, tbl[i].exp_id);
      chk($sformatf("v%0d_done", i), dn, tbl[i].exp_done);
      chk($sformatf("v%0d_fail", i), fl, tbl[i].exp_fail);
    end

    // Reset while a frame is in flight, then the idle run must be rebuilt from zero.
    ids = mk('h010, 'h020, 'h030, 'h040);
    sif.req = 4'b0001; sif.req_id = ids;
    got = 0; n = 0;
    while (!got && n < 300) begin
      sif.bit_tick = (n % 4 == 3); sif.bus_dom = 0;
      step();
      n++;
      if (sif.tx_start) got = 1;
    end
    if (!got) timeout("midframe_start");
    sif.bit_tick = 0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", sif.gnt, 0);
    chk("arst_tx_start", sif.tx_start, 0);
    chk("arst_done_fail", {sif.done, sif.fail}, 0);
    chk("arst_bus_idle", sif.bus_idle, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 0;
    foreach (rc[i]) rc[i] = 0;
    for (int k = 0; k < 40; k++) begin
      sif.bit_tick = (k % 4 == 3);
      step();
      if (k % 4 == 3) run++;
      chk("post_rst_no_start", sif.tx_start, 0);
      chk("post_rst_no_gnt", sif.gnt, 0);
    end
    do_frame(4'b0001, ids, 0, EV_D, 1'b0, g, id, dn, fl);
    chk("post_rst_gnt", g, 4'b0001);
    chk("post_rst_id", id, 'h010);
    chk("post_rst_done", dn, 4'b0001);

    // Randomized frames against the model: lowest {id,index} key wins, errors count to MAXR.
    for (int t = 0; t < 60; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        ids[i] = ($urandom_range(0, 1) == 1) ? ID_W'($urandom_range(0, 3)) : ID_W'($urandom_range(0, 2047));
      ev = 3'($urandom_range(1, 7));
      best = -1; w = 0;
      for (int i = 0; i < NREQ; i++) begin
        key = int'(ids[i]) * NREQ + i;
        if (m[i] && (best < 0 || key < best)) begin best = key; w = i; end
      end
      oh = '0; oh[w] = 1'b1;
      do_frame(m, ids, 0, ev, 1'b1, g, id, dn, fl);
      chk($sformatf("r%0d_gnt", t), g, oh);
      chk($sformatf("r%0d_id", t), id, ids[w]);
      if (ev[2]) begin
        rc[w] = 0;
        chk($sformatf("r%0d_done", t), dn, oh);
        chk($sformatf("r%0d_fail", t), fl, 0);
      end else if (ev[1]) begin
        rc[w]++;
        chk($sformatf("r%0d_done", t), dn, 0);
        if (rc[w] == MAXR) begin
          rc[w] = 0;
          chk($sformatf("r%0d_fail", t), fl, oh);
        end else chk($sformatf("r%0d_fail", t), fl, 0);
      end else begin
        chk($sformatf("r%0d_done", t), dn, 0);
        chk($sformatf("r%0d_fail", t), fl, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Shares one custom_can_node transmitter between NREQ local requesters (mailboxes).
- Waits for bus idle (IDLE_BITS consecutive recessive bit samples), then grants the pending request with the numerically lowest CAN ID, mirroring on-wire CAN priority.
- Sequences the transmit start and handles completion, lost arbitration and error retries with a per-requester retry limit.
- Sits between the mailbox logic and the node on the wired-OR bus, where dominant is can_hi = 1.

Parameters:
NREQ, 4, number of requesters
ID_W, 11, CAN identifier width
IDLE_BITS, 11, recessive bit samples required before bus counts as idle
MAX_RETRY, 8, tx_err count at which a request is aborted (1..2^RETRY_W-1)
RETRY_W, 4, retry counter width

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
bit_tick  in  1  one-cycle pulse at each CAN bit sample point
bus_dom  in  1  sampled bus level; 1 = dominant (can_hi)
req  in  NREQ  request pending; held high until done/fail
req_id  in  NREQ*ID_W  request i ID at bits [i*ID_W +: ID_W]
gnt  out  NREQ  one-hot; requester owning the transmitter
done  out  NREQ  one-cycle pulse, frame sent
fail  out  NREQ  one-cycle pulse, aborted after MAX_RETRY errors
tx_start  out  1  one-cycle pulse to node
tx_id  out  ID_W  latched winner ID, stable from tx_start until return to WAIT
tx_done  in  1  pulse from node: frame acknowledged
tx_lost  in  1  pulse from node: arbitration lost
tx_err  in  1  pulse from node: bit/ack/form error
bus_idle  out  1  idle counter saturated at IDLE_BITS

Behaviour:
Reset (async, RST_N=0):
- State WAIT; gnt, done, fail, tx_start = 0; tx_id = 0; idle counter = 0; all retry counters = 0.
- The bus is never assumed idle after reset.

Idle counter (all states):
- On bit_tick with bus_dom=0: increment, saturating at IDLE_BITS.
- On bit_tick with bus_dom=1: clear to 0.
- Cleared on entry to WAIT from ACTIVE.
- bus_idle = (counter == IDLE_BITS).

States WAIT -> GRANT -> START -> ACTIVE -> WAIT:
- WAIT: when bus_idle && |req, latch winner w = index of the lowest req_id among asserted req; ties go to the lowest index. Move to GRANT.
- GRANT (1 cycle): gnt[w] = 1; tx_id = req_id[w] latched. Move to START.
- START (1 cycle): tx_start = 1. Move to ACTIVE. gnt[w] stays high.
- ACTIVE: wait for a node pulse.
  - tx_done: done[w] pulse next cycle; retry[w] = 0; gnt = 0; go to WAIT.
  - tx_lost: no count change; gnt = 0; go to WAIT and re-arbitrate. Unlimited lost-arbitration retries.
  - tx_err: retry[w]+1. If the new value == MAX_RETRY, fail[w] pulse and retry[w] = 0. Either way gnt = 0 and go to WAIT.
  - Simultaneous events: priority tx_done > tx_err > tx_lost.

Latency and event rules:
- Idle detect to tx_start = 2 CLK cycles.
- tx_done/tx_lost/tx_err outside ACTIVE are ignored.
- req deassertion during GRANT/START/ACTIVE is ignored; the frame still completes. In WAIT, deasserted requesters are excluded from selection.
- After done/fail, a requester that is still asserted is treated as a new request.

Invariants:
- gnt is zero or one-hot.
- done and fail are never asserted together.
- At most one done/fail pulse per ACTIVE exit.

Decomposition:
- Package can_pkg:
  - CAN_ID_W = 11
  - BUS_DOMINANT = 1'b1
  - IDLE_BITS default
  - State enum {S_WAIT, S_GRANT, S_START, S_ACTIVE}
- Sub-module can_prio_select: combinational lowest-ID, lowest-index tie-break over NREQ entries. Outputs a one-hot winner and a valid flag. Reusable by the receive-filter logic.
- The rest (FSM, idle counter, retry array) stays in can_tx_scheduler.

Test Plan:
- Idle/grant/done: after reset, bus recessive, bit_tick every 4 CLK; req[0] with id 0x123 -> tx_start exactly 2 cycles after the 11th recessive tick, tx_id=0x123, gnt=0001. Pulse tx_done -> done=0001 for one cycle, gnt=0000.
- Priority: req[1] id 0x050 and req[2] id 0x700 raised together -> gnt=0010 first. After tx_done, 11 fresh idle ticks, then gnt=0100 with tx_id=0x700.
- Tie and idle restart: req[0] and req[3] both id 0x100, with a dominant sample at the 7th idle tick -> counter restarts. tx_start only after 11 further recessive ticks, and gnt=0001.
- Retry limit: MAX_RETRY=3, req[2] id 0x200, node returns tx_err each attempt -> exactly 3 tx_start pulses, then fail=0100 once, done never set. Repeat with 5 tx_lost then tx_done -> no fail, done=0100.
- Simultaneous events: tx_done and tx_err in the same cycle -> done pulse, retry[w] unchanged at 0, no fail.
- Reset mid-frame: RST_N low during ACTIVE -> gnt, tx_start, done, fail = 0 immediately (async). After release with req held, no tx_start until 11 recessive ticks have elapsed.
